day4_pipe_reg: RTL and testbench

Parametrised registered delay line with a valid tag per stage, a stall enable, an optional synchronous clear and an occupancy counter. It generalises the single flip-flop to a WIDTH-bit, DEPTH-stage pipeline register. It sits between producer and consumer logic to retime or delay data by a fixed number of cycles while tracking which stages hold live samples.

---
 rtl/day4_pipe_reg.sv | 84 ++++++++
 tb/tb_day4_pipe_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/day4_pipe_reg.sv
// rtl/day4_pipe_reg.sv - WIDTH-bit, DEPTH-stage pipeline register with per-stage valid tags and occupancy count
// Optional synchronous clear port clr_i is built only when DAY4_SYNC_CLR_EN is defined.
module day4_pipe_reg #(
  parameter int              WIDTH   = 8,
  parameter int              DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int             CW      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en_i,
`ifdef DAY4_SYNC_CLR_EN
  input  logic                   clr_i,
`endif
  input  logic [WIDTH-1:0]       d_i,
  input  logic                   valid_i,
  output logic [WIDTH-1:0]       q_o,
  output logic                   valid_o,
  output logic [WIDTH*DEPTH-1:0] taps_o,
  output logic [CW-1:0]          occ_o
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] tag_q;
  logic [DEPTH-1:0] tag_d;
  logic [CW-1:0]    occ_q;
  logic [CW-1:0]    occ_d;

  // Later assignments override earlier ones, so clear takes priority over advance.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      data_d[k] = data_q[k];
    end
    tag_d = tag_q;
    occ_d = occ_q;

    if (en_i) begin
      data_d[0] = d_i;
      tag_d[0]  = valid_i;
      for (int k = 1; k < DEPTH; k++) begin
        data_d[k] = data_q[k-1];
        tag_d[k]  = tag_q[k-1];
      end
      // The counter tracks popcount(tag), so entry/exit balance keeps it in range.
      occ_d = occ_q + CW'(valid_i) - CW'(tag_q[DEPTH-1]);
    end

`ifdef DAY4_SYNC_CLR_EN
    if (clr_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_d[k] = RST_VAL;
      end
      tag_d = '0;
      occ_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RST_VAL;
      end
      tag_q <= '0;
      occ_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
      tag_q <= tag_d;
      occ_q <= occ_d;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_taps
    assign taps_o[k*WIDTH +: WIDTH] = data_q[k];
  end

  assign q_o     = data_q[DEPTH-1];
  assign valid_o = tag_q[DEPTH-1];
  assign occ_o   = occ_q;

endmodule

// File: tb/tb_day4_pipe_reg.sv
// tb/tb_day4_pipe_reg.sv - scoreboard bench for day4_pipe_reg (WIDTH=8, DEPTH=4, RST_VAL=A5)
module tb_day4_pipe_reg;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);
  localparam logic [W-1:0] RV = 8'hA5;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           en_i = 1'b0;
  logic           clr_i = 1'b0;
  logic [W-1:0]   d_i = '0;
  logic           valid_i = 1'b0;
  logic [W-1:0]   q_o;
  logic           valid_o;
  logic [W*D-1:0] taps_o;
  logic [CW-1:0]  occ_o;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [W-1:0] d;
    logic         v;
  } ent_t;

  // Expected stage contents, front = output stage, back = stage 0.
  ent_t sb[$];

  day4_pipe_reg #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV)) dut (
    .clk     (clk),
    .reset   (reset),
    .en_i    (en_i),
`ifdef DAY4_SYNC_CLR_EN
    .clr_i   (clr_i),
`endif
    .d_i     (d_i),
    .valid_i (valid_i),
    .q_o     (q_o),
    .valid_o (valid_o),
    .taps_o  (taps_o),
    .occ_o   (occ_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic sb_flush();
    sb.delete();
    for (int j = 0; j < D; j++) sb.push_back({RV, 1'b0});
  endtask

  task automatic check_outputs();
    logic [W*D-1:0] exp_taps;
    int             exp_occ;
    exp_occ = 0;
    for (int j = 0; j < D; j++) begin
      exp_taps[(D-1-j)*W +: W] = sb[j].d;
      if (sb[j].v) exp_occ++;
    end
    check_eq("q_o", 32'(q_o), 32'(sb[0].d));
    check_eq("valid_o", 32'(valid_o), 32'(sb[0].v));
    check_eq("taps_o", 32'(taps_o), 32'(exp_taps));
    check_eq("occ_o", 32'(occ_o), 32'(exp_occ));
  endtask

  task automatic step(input logic en, input logic v, input logic [W-1:0] d, input logic clr);
    logic clr_eff;
`ifdef DAY4_SYNC_CLR_EN
    clr_eff = clr;
`else
    clr_eff = 1'b0;
`endif
    en_i = en; valid_i = v; d_i = d; clr_i = clr;
    @(posedge clk);
    if (clr_eff) begin
      sb_flush();
    end else if (en) begin
      void'(sb.pop_front());
      sb.push_back({d, v});
    end
    #1;
    check_outputs();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    sb_flush();
    check_outputs();
    check_eq("async_rst_taps", 32'(taps_o), 32'hA5A5A5A5);
    #1;
    reset = 1'b1;
  endtask

  int         first_v;
  logic [7:0] stall_q [3];
  int         nq;

  initial begin
    // Reset asserted between edges must take effect with no clock.
    #2 reset = 1'b0;
    #1;
    sb_flush();
    check_outputs();
    check_eq("rst_q", 32'(q_o), 32'hA5);
    check_eq("rst_taps", 32'(taps_o), 32'hA5A5A5A5);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;

    // Stream 01..05
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1, 8'(i), 1'b0);
      check_eq("strm_occ", 32'(occ_o), 32'(i < 4 ? i : 4));
      if (i == 4) check_eq("strm_q4", {23'd0, valid_o, q_o}, 32'h101);
      if (i == 5) check_eq("strm_q5", 32'(q_o), 32'h02);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("strm_q6", 32'(q_o), 32'h03);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0);

    // Stall for 2 cycles after 02 is accepted
    first_v = 0;
    nq = 0;
    for (int i = 1; i <= 10; i++) begin
      case (i)
        1:       step(1'b1, 1'b1, 8'h01, 1'b0);
        2:       step(1'b1, 1'b1, 8'h02, 1'b0);
        3, 4:    step(1'b0, 1'b1, 8'hEE, 1'b0);
        5:       step(1'b1, 1'b1, 8'h03, 1'b0);
        default: step(1'b1, 1'b0, 8'h00, 1'b0);
      endcase
      if (i == 3 || i == 4) begin
        check_eq("stall_taps", 32'(taps_o), 32'h00000102);
        check_eq("stall_occ", 32'(occ_o), 32'd2);
      end
      if (valid_o && nq < 3) begin
        if (first_v == 0) first_v = i;
        stall_q[nq] = q_o;
        nq++;
      end
    end
    check_eq("stall_lat", 32'(first_v), 32'd6);
    check_eq("stall_seq", {8'd0, stall_q[0], stall_q[1], stall_q[2]}, 32'h00010203);

    // Bubble 1,0,1
    step(1'b1, 1'b1, 8'h11, 1'b0);
    check_eq("bub_occ1", 32'(occ_o), 32'd1);
    step(1'b1, 1'b0, 8'h22, 1'b0);
    check_eq("bub_occ2", 32'(occ_o), 32'd1);
    step(1'b1, 1'b1, 8'h33, 1'b0);
    check_eq("bub_occ3", 32'(occ_o), 32'd2);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("bub_out1", {23'd0, valid_o, q_o}, 32'h111);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("bub_out2", {23'd0, valid_o, q_o}, 32'h022);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("bub_out3", {23'd0, valid_o, q_o}, 32'h133);

`ifdef DAY4_SYNC_CLR_EN
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b1);
    check_eq("clr_occ", 32'(occ_o), 32'd0);
    check_eq("clr_taps", 32'(taps_o), 32'hA5A5A5A5);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      check_eq("clr_no77", 32'(valid_o), 32'd0);
    end
`endif

    // Random traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
           ($urandom_range(0, 19) == 0));
    end

    // Async reset mid-stream with a full pipe
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h50 + i), 1'b0);
    pulse_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 8'(8'h60 + i), 1'b0);
      if (i < 4) check_eq("rst_restart_v", 32'(valid_o), 32'd0);
    end
    check_eq("rst_restart_q", {23'd0, valid_o, q_o}, 32'h161);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
